// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared fetch/decode types, widths and opcode-field helpers
package rv_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Opcode field position, shared with decode.
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    // Redirect targets are forced onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory and IF/ID handshake bundle
//
// master : fetch side  (drives imem_addr and IF/ID contents)
// slave  : memory/decode side (drives imem_instr and id_ready)
interface fetch_if;

    logic [rv_pkg::ADDR_W-1:0]  imem_addr;
    logic [rv_pkg::INSTR_W-1:0] imem_instr;
    logic                       id_ready;
    logic                       if_id_valid;
    logic [rv_pkg::ADDR_W-1:0]  if_id_pc;
    logic [rv_pkg::INSTR_W-1:0] if_id_instr;

    modport master (
        output imem_addr,
        output if_id_valid,
        output if_id_pc,
        output if_id_instr,
        input  imem_instr,
        input  id_ready
    );

    modport slave (
        input  imem_addr,
        input  if_id_valid,
        input  if_id_pc,
        input  if_id_instr,
        output imem_instr,
        output id_ready
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with load/hold/flush
//
// Ports: clk, rst_n (sync active-low), i_load, i_flush, i_pc, i_instr,
//        o_valid, o_pc, o_instr.
// Flush wins over load; with neither asserted the contents hold.
module if_id_reg
    import rv_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_valid,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_instr
);

    logic               r_valid;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= NOP;
        end else if (i_flush) begin
            // pc is left as-is; only valid/instr define a bubble.
            r_valid <= 1'b0;
            r_instr <= NOP;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter, fetch FSM and IF/ID capture
//
// Ports: clk, rst_n (sync active-low), bus (fetch_if.master: imem_addr,
//        imem_instr, id_ready, if_id_valid/pc/instr), branch_taken,
//        branch_target, halted, misalign_err.
// Optional: FETCH_PERF_CNT_EN adds fetch_count / stall_count (saturating).
module fetch_stage #(
    parameter logic [rv_pkg::ADDR_W-1:0]  RESET_PC    = 8'h00,
    parameter logic [rv_pkg::INSTR_W-1:0] NOP_INSTR   = 32'h0000_0013,
    parameter logic [6:0]                 HALT_OPCODE = 7'b1110011
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fetch_if.master                   bus,
    input  logic                      branch_taken,
    input  logic [rv_pkg::ADDR_W-1:0] branch_target,
    output logic                      halted,
    output logic                      misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]               fetch_count,
    output logic [15:0]               stall_count
`endif
);

    import rv_pkg::*;

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_halted;
    logic               r_misalign;

    logic               w_valid;
    logic [ADDR_W-1:0]  w_id_pc;
    logic [INSTR_W-1:0] w_id_instr;

    logic w_redirect;
    logic w_stall;
    logic w_advance;
    logic w_drain;
    logic w_flush;
    logic w_is_halt;

    assign w_redirect = branch_taken;
    assign w_stall    = (r_state == ST_RUN) && !w_redirect && w_valid && !bus.id_ready;
    assign w_advance  = (r_state == ST_RUN) && !w_redirect && !w_stall;
    // In HALT the last instruction is handed off, then IF/ID empties.
    assign w_drain    = (r_state == ST_HALT) && !w_redirect && w_valid && bus.id_ready;
    assign w_flush    = w_redirect || w_drain;
    assign w_is_halt  = (opcode_of(bus.imem_instr) == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (w_redirect) begin
                // Redirect is legal from every state and always resumes RUN.
                r_pc       <= word_align(branch_target);
                r_misalign <= (branch_target[1:0] != 2'b00);
                r_halted   <= 1'b0;
                r_state    <= ST_RUN;
            end else begin
                case (r_state)
                    ST_BOOT: r_state <= ST_RUN;
                    ST_RUN: begin
                        if (w_advance) begin
                            r_pc <= r_pc + ADDR_W'(4);
                            if (w_is_halt) begin
                                r_state  <= ST_HALT;
                                r_halted <= 1'b1;
                            end
                        end
                    end
                    ST_HALT: ;
                    default: r_state <= ST_BOOT;
                endcase
            end
        end
    end

    if_id_reg #(
        .NOP(NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_advance),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_instr (bus.imem_instr),
        .o_valid (w_valid),
        .o_pc    (w_id_pc),
        .o_instr (w_id_instr)
    );

    assign bus.imem_addr   = r_pc;
    assign bus.if_id_valid = w_valid;
    assign bus.if_id_pc    = w_id_pc;
    assign bus.if_id_instr = w_id_instr;
    assign halted          = r_halted;
    assign misalign_err    = r_misalign;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_advance && (r_fetch_cnt != 16'hFFFF))
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            if (w_stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       halted;
    logic       misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    fetch_if bus ();

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted),
        .misalign_err  (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    assign bus.imem_instr = mem[bus.imem_addr[7:2]];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what fetch should look like after each edge.
    logic [7:0]  m_pc;
    bit          m_booting;
    bit          m_halt;
    bit          m_mis;
    bit          m_valid;
    logic [7:0]  m_id_pc;
    logic [31:0] m_id_instr;
    int          m_fetches;
    int          m_stalls;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if (w[6:0] == 7'h73) w[6:0] = 7'h33;
        return w;
    endfunction

    task automatic model_edge(input bit rst, input bit rdy, input bit br, input logic [7:0] tgt);
        if (!rst) begin
            m_pc = 8'h00; m_booting = 1; m_halt = 0; m_mis = 0;
            m_valid = 0; m_id_pc = 8'h00; m_id_instr = 32'h13;
            m_fetches = 0; m_stalls = 0;
            return;
        end
        m_mis = 0;
        if (br) begin
            m_pc = tgt & 8'hFC;
            m_mis = (tgt % 4) != 0;
            m_valid = 0; m_id_instr = 32'h13;
            m_booting = 0; m_halt = 0;
        end else if (m_booting) begin
            m_booting = 0;
        end else if (m_halt) begin
            if (m_valid && rdy) begin
                m_valid = 0; m_id_instr = 32'h13;
            end
        end else if (m_valid && !rdy) begin
            if (m_stalls < 65535) m_stalls++;
        end else begin
            m_valid = 1;
            m_id_pc = m_pc;
            m_id_instr = mem[m_pc / 4];
            m_pc = 8'((m_pc + 4) % 256);
            if (m_fetches < 65535) m_fetches++;
            if ((m_id_instr & 32'h7F) == 32'h73) m_halt = 1;
        end
    endtask

    task automatic step(input bit rst, input bit rdy, input bit br, input logic [7:0] tgt);
        rst_n = rst; bus.id_ready = rdy; branch_taken = br; branch_target = tgt;
        @(posedge clk);
        model_edge(rst, rdy, br, tgt);
        #1;
        check_eq("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
        check_eq("valid", 32'(bus.if_id_valid), 32'(m_valid));
        check_eq("if_id_pc", 32'(bus.if_id_pc), 32'(m_id_pc));
        check_eq("if_id_instr", bus.if_id_instr, m_id_instr);
        check_eq("halted", 32'(halted), 32'(m_halt));
        check_eq("misalign", 32'(misalign_err), 32'(m_mis));
`ifdef FETCH_PERF_CNT_EN
        check_eq("fetch_count", 32'(fetch_count), 32'(m_fetches));
        check_eq("stall_count", 32'(stall_count), 32'(m_stalls));
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = rand_instr();
        rst_n = 0; bus.id_ready = 1; branch_taken = 0; branch_target = 8'h00;

        // Reset and BOOT
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        check_eq("rst_instr", bus.if_id_instr, 32'h0000_0013);
        step(1, 1, 0, 8'h00);
        check_eq("boot_valid", 32'(bus.if_id_valid), 32'd0);

        // Free-run, then 3-cycle stall at 0x08
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 8'h00);
            check_eq("run_pc", 32'(bus.if_id_pc), 32'(i * 4));
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 8'h00);
            check_eq("stall_pc", 32'(bus.imem_addr), 32'h0C);
            check_eq("stall_id", 32'(bus.if_id_pc), 32'h08);
        end
        step(1, 1, 0, 8'h00);
        check_eq("release_pc", 32'(bus.if_id_pc), 32'h0C);

        // Redirect overrides a stall; misaligned redirect
        step(1, 0, 1, 8'h20);
        check_eq("flush_valid", 32'(bus.if_id_valid), 32'd0);
        check_eq("br_pc", 32'(bus.imem_addr), 32'h20);
        step(1, 1, 0, 8'h00);
        check_eq("br_fetch", 32'(bus.if_id_pc), 32'h20);
        step(1, 1, 1, 8'h23);
        check_eq("mis_pc", 32'(bus.imem_addr), 32'h20);
        check_eq("mis_hi", 32'(misalign_err), 32'd1);
        step(1, 1, 0, 8'h00);
        check_eq("mis_lo", 32'(misalign_err), 32'd0);

        // Halt on SYSTEM word at 0x10, then escape by branch
        mem[4] = 32'h0000_0073;
        step(1, 1, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 8'h00);
        check_eq("halt_flag", 32'(halted), 32'd1);
        check_eq("halt_valid", 32'(bus.if_id_valid), 32'd1);
        check_eq("halt_id_pc", 32'(bus.if_id_pc), 32'h10);
        for (int i = 0; i < 3; i++) step(1, 1'($urandom_range(0, 1)), 0, 8'h00);
        check_eq("halt_frozen", 32'(bus.imem_addr), 32'h14);
        step(1, 1, 1, 8'h00);
        check_eq("unhalt", 32'(halted), 32'd0);
        step(1, 1, 0, 8'h00);
        check_eq("refetch", 32'(bus.if_id_pc), 32'h00);
        mem[4] = rand_instr();

        // Wrap past 0xFC
        step(1, 1, 1, 8'hF0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8'h00);
        check_eq("wrap_addr", 32'(bus.imem_addr), 32'h00);
        check_eq("wrap_id_pc", 32'(bus.if_id_pc), 32'hFC);

`ifdef FETCH_PERF_CNT_EN
        step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        for (int i = 0; i < 64; i++) step(1, 1, 0, 8'h00);
        check_eq("fetch64", 32'(fetch_count), 32'd64);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00);
        check_eq("stall5", 32'(stall_count), 32'd5);
`endif

        // Randomized traffic, including halts and occasional resets
        for (int i = 0; i < 600; i++) begin
            if (i == 300) mem[$urandom_range(0, 63)] = 32'h0000_0073 | ($urandom & 32'hFFFF_FF80);
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0),
                 8'($urandom));
        end

        // Reset mid-operation
        step(1, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        check_eq("midrst_valid", 32'(bus.if_id_valid), 32'd0);
        check_eq("midrst_pc", 32'(bus.imem_addr), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Upstream neighbour of the instruction memory: owns the program counter and drives the 8-bit byte address into the memory.
- Captures the returned 32-bit little-endian-assembled instruction into an IF/ID pipeline register for the decode stage.
- Handles decode back-pressure, branch redirect/flush from the execute stage, and halt on a SYSTEM-opcode instruction.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble pattern (addi x0,x0,0) placed in if_id_instr when invalid.
- HALT_OPCODE, 7'b1110011, opcode field (bits[6:0]) that stops fetch.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_addr  out  8  byte address to instruction memory; combinationally equals pc.
- imem_instr  in  32  instruction returned by memory for imem_addr, same cycle (async read).
- id_ready  in  1  decode stage can accept the IF/ID contents this cycle.
- branch_taken  in  1  execute-stage redirect request, single-cycle pulse.
- branch_target  in  8  redirect byte address; sampled when branch_taken=1.
- if_id_valid  out  1  IF/ID register holds a real instruction.
- if_id_pc  out  8  address the held instruction was fetched from.
- if_id_instr  out  32  held instruction; NOP_INSTR whenever if_id_valid=0.
- halted  out  1  fetch stopped after a HALT_OPCODE instruction.
- misalign_err  out  1  one-cycle pulse: branch_target[1:0]!=0 on a redirect.

Behaviour:
- Reset, with rst_n=0 at an edge:
  - pc=RESET_PC, state=BOOT.
  - if_id_valid=0, if_id_pc=8'h00, if_id_instr=NOP_INSTR.
  - halted=0, misalign_err=0.
  - Reset mid-operation discards all in-flight state.
- States: BOOT, RUN, HALT.
- BOOT:
  - Lasts one cycle; if_id stays invalid; pc is held.
  - Next state is RUN unconditionally, unless branch_taken=1, which applies the redirect rule and goes to RUN.
- RUN, priority per edge:
  1. Redirect (branch_taken=1):
     - pc <= {branch_target[7:2],2'b00}.
     - IF/ID flushed: valid=0, instr=NOP_INSTR.
     - misalign_err <= (branch_target[1:0]!=0).
     - Overrides stall and halt detection.
  2. Stall (if_id_valid=1 and id_ready=0): pc and IF/ID held unchanged.
  3. Advance:
     - IF/ID <= {valid=1, pc, imem_instr}.
     - pc <= pc+4, modulo 256 (8'hFC wraps to 8'h00).
- Halt entry:
  - On an Advance that captures imem_instr[6:0]==HALT_OPCODE, state <= HALT.
  - The halt instruction itself is delivered to decode with valid=1.
  - halted <= 1 on the same edge; pc <= pc+4 but is frozen from then on.
- HALT:
  - No new captures.
  - If id_ready=1 while valid, valid <= 0 and instr <= NOP_INSTR.
  - branch_taken=1 applies the redirect rule, clears halted, and returns to RUN (older branch squashes the wrong-path halt).
- Latency: the instruction at address A appears in if_id_instr one edge after pc==A with no stall; back-to-back throughput is one per cycle.
- misalign_err is deasserted in every cycle without a misaligned redirect.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds ports fetch_count out 16 and stall_count out 16, both reset to 0.
  - fetch_count increments on every Advance.
  - stall_count increments on every RUN cycle taking the Stall path.
  - Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package rv_pkg:
  - fetch state enum (BOOT/RUN/HALT).
  - ADDR_W=8, INSTR_W=32, NOP_INSTR, OPC_SYSTEM, OPC_BRANCH.
  - opcode-field slice constants reused by decode.
- One natural sub-module: if_id_reg, the valid/pc/instr register with load, hold and flush controls.
- PC/FSM logic stays in fetch_stage.

Test Plan:
- Reset then free-run with id_ready=1:
  - BOOT cycle shows valid=0, instr=32'h00000013.
  - Next edges give if_id_pc=00,04,08 with instrs matching memory.
- Hold id_ready=0 for 3 cycles at if_id_pc=8'h08: pc stays 8'h0C, IF/ID unchanged; on release, if_id_pc=8'h0C next edge.
- branch_taken=1, target=8'h20, asserted together with id_ready=0:
  - Next edge valid=0 (flushed), pc=8'h20.
  - Following edge if_id_pc=8'h20.
- branch_taken with target=8'h23: pc=8'h20 and misalign_err high for exactly one cycle.
- Memory word 32'h00000073 at 8'h10:
  - Delivered with valid=1, halted=1, pc frozen at 8'h14.
  - Later branch_taken target=8'h00 clears halted and refetches 8'h00.
- Run to 8'hFC with id_ready=1: next pc=8'h00. With FETCH_PERF_CNT_EN, fetch_count=64 after 64 advances and stall_count equals the number of stall cycles.
